hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_stall_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard controller: E/M/W destination shadow pipeline, RAW and HI/LO stall logic.
// Optional macro HAZARD_STATS_EN adds a free-running 32-bit stall-cycle counter on stall_count.
module hazard_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic [1:0]  D_Tuse1,
   input  logic [1:0]  D_Tuse2,
   input  logic [1:0]  D_Tnew,
   input  logic [4:0]  D_wa,
   input  logic        D_md_use,
   input  logic        D_md_start,
   input  logic        D_md_div,
   output logic        stall,
   output logic [4:0]  E_wa,
   output logic [4:0]  M_wa,
   output logic [4:0]  W_wa,
   output logic [1:0]  E_Tnew,
   output logic [1:0]  M_Tnew,
   output logic        md_busy,
   output logic [31:0] stall_count
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [4:0]       e_wa_r;
   logic [1:0]       e_tnew_r;
   logic             e_md_start_r;
   logic             e_md_div_r;
   logic [4:0]       m_wa_r;
   logic [1:0]       m_tnew_r;
   logic [4:0]       w_wa_r;
   logic [CNT_W-1:0] md_cnt_r;
   logic             stall_rs_s;
   logic             stall_rt_s;
   logic             stall_md_s;
   logic             md_busy_s;
   logic             stall_s;

   function automatic logic [1:0] sat_dec(input logic [1:0] x);
      sat_dec = (x == 2'd0) ? 2'd0 : x - 2'd1;
   endfunction

   // A producer still further from its result than the consumer's deadline cannot be forwarded.
   function automatic logic raw_hit(input logic [4:0] addr, input logic [1:0] tuse,
                                    input logic [4:0] ewa, input logic [1:0] etnew,
                                    input logic [4:0] mwa, input logic [1:0] mtnew);
      raw_hit = (addr != 5'd0) && (tuse != 2'd3) &&
                (((ewa == addr) && (etnew > tuse)) || ((mwa == addr) && (mtnew > tuse)));
   endfunction

   // Hazard detection and stall combine.
   always_comb begin
      stall_rs_s = raw_hit(D_rs, D_Tuse1, e_wa_r, e_tnew_r, m_wa_r, m_tnew_r);
      stall_rt_s = raw_hit(D_rt, D_Tuse2, e_wa_r, e_tnew_r, m_wa_r, m_tnew_r);
      md_busy_s  = e_md_start_r | (md_cnt_r != {CNT_W{1'b0}});
      stall_md_s = D_md_use & md_busy_s;
      stall_s    = stall_rs_s | stall_rt_s | stall_md_s;
   end

   // Shadow pipeline advance; a stalled D instruction leaves a bubble in E.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         e_wa_r       <= 5'd0;
         e_tnew_r     <= 2'd0;
         e_md_start_r <= 1'b0;
         e_md_div_r   <= 1'b0;
         m_wa_r       <= 5'd0;
         m_tnew_r     <= 2'd0;
         w_wa_r       <= 5'd0;
      end else begin
         if (stall_s) begin
            e_wa_r       <= 5'd0;
            e_tnew_r     <= 2'd0;
            e_md_start_r <= 1'b0;
            e_md_div_r   <= 1'b0;
         end else begin
            e_wa_r       <= D_wa;
            e_tnew_r     <= D_Tnew;
            e_md_start_r <= D_md_start;
            e_md_div_r   <= D_md_div;
         end
         m_wa_r   <= e_wa_r;
         m_tnew_r <= sat_dec(e_tnew_r);
         w_wa_r   <= m_wa_r;
      end
   end

   // Mult/div busy countdown, loaded as the launching instruction leaves E.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         md_cnt_r <= {CNT_W{1'b0}};
      end else if (e_md_start_r) begin
         md_cnt_r <= e_md_div_r ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (md_cnt_r != {CNT_W{1'b0}}) begin
         md_cnt_r <= md_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         md_cnt_r <= md_cnt_r;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count_r;

   // Stall-cycle statistics counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_count_r <= 32'd0;
      end else if (stall_s) begin
         stall_count_r <= stall_count_r + 32'd1;
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

   assign stall_count = stall_count_r;
`else
   assign stall_count = 32'd0;
`endif

   assign stall   = stall_s;
   assign md_busy = md_busy_s;
   assign E_wa    = e_wa_r;
   assign E_Tnew  = e_tnew_r;
   assign M_wa    = m_wa_r;
   assign M_Tnew  = m_tnew_r;
   assign W_wa    = w_wa_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (honours HAZARD_STATS_EN when defined).
module tb_hazard_stall_ctrl;

   logic        clk;
   logic        reset_n;
   logic [4:0]  D_rs;
   logic [4:0]  D_rt;
   logic [1:0]  D_Tuse1;
   logic [1:0]  D_Tuse2;
   logic [1:0]  D_Tnew;
   logic [4:0]  D_wa;
   logic        D_md_use;
   logic        D_md_start;
   logic        D_md_div;
   logic        stall;
   logic [4:0]  E_wa;
   logic [4:0]  M_wa;
   logic [4:0]  W_wa;
   logic [1:0]  E_Tnew;
   logic [1:0]  M_Tnew;
   logic        md_busy;
   logic [31:0] stall_count;

   int n_checks;
   int n_pass;

   hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset_n(reset_n),
      .D_rs(D_rs), .D_rt(D_rt), .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2),
      .D_Tnew(D_Tnew), .D_wa(D_wa), .D_md_use(D_md_use),
      .D_md_start(D_md_start), .D_md_div(D_md_div),
      .stall(stall), .E_wa(E_wa), .M_wa(M_wa), .W_wa(W_wa),
      .E_Tnew(E_Tnew), .M_Tnew(M_Tnew), .md_busy(md_busy),
      .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu1,
                        input logic [1:0] tu2, input logic [1:0] tnew, input logic [4:0] wa,
                        input logic use_md, input logic start, input logic div);
      D_rs = rs; D_rt = rt; D_Tuse1 = tu1; D_Tuse2 = tu2; D_Tnew = tnew; D_wa = wa;
      D_md_use = use_md; D_md_start = start; D_md_div = div;
      #1;
   endtask

   task automatic set_idle();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // lw $8 followed by beq $8,$0: two stall cycles, then the load reaches W.
   task automatic lw_beq();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd2, 5'd8, 1'b0, 1'b0, 1'b0);
      check_value("lw_no_stall", {31'd0, stall}, 32'd0);
      tick();
      set_d(5'd8, 5'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_value("beq_stall_e", {31'd0, stall}, 32'd1);
      check_value("lw_e_tnew", {30'd0, E_Tnew}, 32'd2);
      tick();
      check_value("beq_stall_m", {31'd0, stall}, 32'd1);
      check_value("lw_m_tnew", {30'd0, M_Tnew}, 32'd1);
      check_value("bubble_e_wa", {27'd0, E_wa}, 32'd0);
      tick();
      check_value("beq_released", {31'd0, stall}, 32'd0);
      check_value("lw_w_wa", {27'd0, W_wa}, 32'd8);
      tick();
      set_idle();
   endtask

   // Launch an md op then hold an mfhi/mflo at D, counting stalled cycles.
   task automatic md_seq(input logic div, input int exp_cycles, input string tag);
      int n;
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd0, 1'b1, 1'b1, div);
      check_value({tag, "_launch_free"}, {31'd0, stall}, 32'd0);
      tick();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd1, 5'd2, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (stall && n < 40) begin
         if (md_busy !== 1'b1) check_value({tag, "_busy_while_stall"}, {31'd0, md_busy}, 32'd1);
         n++;
         tick();
      end
      check_value({tag, "_stall_cycles"}, n, exp_cycles);
      check_value({tag, "_busy_clear"}, {31'd0, md_busy}, 32'd0);
      tick();
      set_idle();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      set_d(5'd5, 5'd5, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      check_value("rst_stall", {31'd0, stall}, 32'd0);
      check_value("rst_md_busy", {31'd0, md_busy}, 32'd0);
      check_value("rst_wa", {17'd0, E_wa, M_wa, W_wa}, 32'd0);
      check_value("rst_tnew", {28'd0, E_Tnew, M_Tnew}, 32'd0);
      check_value("rst_stall_count", stall_count, 32'd0);
      reset_n = 1'b1;
      set_idle();

      lw_beq();
      lw_beq();
`ifdef HAZARD_STATS_EN
      check_value("stall_count_4", stall_count, 32'd4);
`else
      check_value("stall_count_off", stall_count, 32'd0);
`endif

      // addu $9 then sw with $9 as rt: forwarding covers it.
      set_d(5'd0, 5'd0, 2'd1, 2'd1, 2'd1, 5'd9, 1'b0, 1'b0, 1'b0);
      tick();
      set_d(5'd0, 5'd9, 2'd1, 2'd2, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_value("sw_no_stall_e", {31'd0, stall}, 32'd0);
      check_value("addu_e_wa", {27'd0, E_wa}, 32'd9);
      check_value("addu_e_tnew", {30'd0, E_Tnew}, 32'd1);
      tick();
      check_value("sw_no_stall_m", {31'd0, stall}, 32'd0);
      check_value("addu_m_wa", {27'd0, M_wa}, 32'd9);
      check_value("addu_m_tnew", {30'd0, M_Tnew}, 32'd0);

      // Producer of $0 with Tnew=2 followed by a Tuse=0 read of $0.
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd2, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      set_d(5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_value("zero_reg_e_tnew", {30'd0, E_Tnew}, 32'd2);
      check_value("zero_reg_no_stall", {31'd0, stall}, 32'd0);
      tick();
      set_idle();
      tick();

      md_seq(1'b1, 11, "div");
      md_seq(1'b0, 6, "mult");

      // Reset while the divider is busy.
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      tick();
      set_idle();
      tick();
      tick();
      check_value("mid_busy", {31'd0, md_busy}, 32'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      check_value("mid_rst_busy", {31'd0, md_busy}, 32'd0);
      check_value("mid_rst_stall", {31'd0, stall}, 32'd0);
      check_value("mid_rst_count", stall_count, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
